reg_file_onehot: RTL and testbench
==================================

Name: reg_file_onehot

Overview:
- Parametrised MIPS general-purpose register file for the multicycle datapath.
- Write-address decoding is built in: the write address is turned into a one-hot enable vector inside the block.
- Register 0 is hardwired to zero. Two asynchronous read ports feed the A/B latches.
- A registered copy of the last committed one-hot write vector and a saturating write counter are provided for debug and bench visibility.

Parameters:
- WIDTH, 32, data width of each register in bits.
- ADDR_W, 5, register address width. Register count DEPTH = 2**ADDR_W (derived localparam, not overridable).
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- reg_write  input  1  write strobe, sampled on rising clk.
- write_r  input  ADDR_W  destination register address.
- write_data  input  WIDTH  data to write.
- read_r1  input  ADDR_W  read port 1 address.
- read_r2  input  ADDR_W  read port 2 address.
- read_data1  output  WIDTH  read port 1 data, combinational.
- read_data2  output  WIDTH  read port 2 data, combinational.
- write_onehot  output  DEPTH  combinational one-hot decode of write_r, gated by reg_write.
- last_write  output  DEPTH  registered one-hot vector of the last committed write.
- write_count  output  CNT_W  number of committed writes, saturating.

Behaviour:
- Clock and reset: single clock domain; clk rising edge; rst_n asynchronous, active-low. Assertion takes effect immediately, mid-operation included. Deassertion is synchronised externally.
- Reset values:
  - all DEPTH registers = 0
  - last_write = 0
  - write_count = 0
  - read_data1/2 = 0 while rst_n is low, because every register is 0.
- Decode:
  - write_onehot[k] = reg_write && (write_r == k) && (k != 0). All other bits are 0.
  - write_r = 0 gives an all-zero vector even with reg_write = 1.
  - Bit k is set for write_r = k (e.g. write_r = 5'd3 gives 32'h0000_0008).
- Write:
  - On a rising clk with rst_n high, every register k whose write_onehot[k] = 1 loads write_data. At most one bit can be set.
  - Latency 1 cycle: data is visible on a read port the cycle after the write edge (unless bypass is enabled, see Optional Feature).
- Register 0: never written and always reads 0, regardless of reg_write or write_data.
- Read:
  - read_dataN = regs[read_rN], combinational, zero-cycle latency.
  - Both ports may address the same register and both return the same value.
- last_write:
  - On a clk edge where write_onehot != 0, last_write <= write_onehot.
  - Otherwise it holds its value, including for writes to register 0 and for idle cycles.
- write_count:
  - Increments by 1 on each edge where write_onehot != 0.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Writes to register 0 are not counted.
- Simultaneous events:
  - Read and write to the same address in one cycle: without bypass the read returns the old value; the new value appears the next cycle.
  - Reset asserted on the same edge as reg_write: reset wins, and nothing is written or counted.
- Out-of-range addresses: none exist, since DEPTH equals the full 2**ADDR_W address space.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: each read port forwards write_data combinationally when reg_write = 1, read_rN == write_r and write_r != 0. Reads of register 0 still return 0.
- Undefined: no forwarding; reads always return stored contents.
- Register, counter and last_write behaviour are identical in both builds.

Test Plan:
- Reset: drive rst_n = 0 mid-run after registers 1-31 hold nonzero data -> all reads return 0, last_write = 0 and write_count = 0 immediately, without waiting for a clk edge.
- Decode sweep: reg_write = 1, write_r = 0..31 with write_data = 32'hA5A5_0000 + k -> write_onehot = 1<<k for k >= 1 and 0 for k = 0. Reading back reg k gives 32'hA5A5_0000 + k, reg 0 reads 0, and write_count = 31.
- Register 0 protection: write 32'hFFFF_FFFF to write_r = 0 -> read_data1 = 0, write_count and last_write unchanged.
- Same-cycle read/write: reg 7 = 32'h1111_1111; write 32'h2222_2222 to reg 7 with read_r1 = 7 in the same cycle -> read_data1 = 32'h1111_1111 without REG_FILE_BYPASS_EN, 32'h2222_2222 with it; 32'h2222_2222 in both builds on the next cycle.
- Counter saturation: CNT_W = 4, 20 consecutive writes to reg 9 -> write_count stops at 4'hF and last_write = 32'h0000_0200.
- Idle hold: reg_write = 0 for 10 cycles with write_r toggling -> write_onehot = 0, register contents, last_write and write_count all unchanged.

Source files
------------

// File: rtl/reg_file_onehot.sv
// reg_file_onehot
//
// MIPS general-purpose register file for the multicycle datapath.
// DEPTH = 2**ADDR_W registers of WIDTH bits. Register 0 is hardwired to zero.
// The write address is decoded into a one-hot enable vector internally. A registered
// copy of the last committed one-hot write and a saturating committed-write counter
// are exposed for debug visibility.
//
// Optional build macro: REG_FILE_BYPASS_EN
//   defined   - read ports forward write_data when the same non-zero register is
//               being written in the same cycle.
//   undefined - reads always return stored contents.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   reg_write    in   write strobe
//   write_r      in   [ADDR_W-1:0] destination register
//   write_data   in   [WIDTH-1:0]  write data
//   read_r1/2    in   [ADDR_W-1:0] read addresses
//   read_data1/2 out  [WIDTH-1:0]  combinational read data
//   write_onehot out  [DEPTH-1:0]  decoded write enables (bit 0 always 0)
//   last_write   out  [DEPTH-1:0]  one-hot vector of the last committed write
//   write_count  out  [CNT_W-1:0]  saturating count of committed writes

module reg_file_onehot #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_r,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_r1,
  input  logic [ADDR_W-1:0] read_r2,
  output logic [WIDTH-1:0]  read_data1,
  output logic [WIDTH-1:0]  read_data2,
  output logic [DEPTH-1:0]  write_onehot,
  output logic [DEPTH-1:0]  last_write,
  output logic [CNT_W-1:0]  write_count
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] last_write_q, last_write_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic             write_commit;

  // Address decode. Bit 0 is forced low so register 0 can never be enabled.
  always_comb begin
    write_onehot = '0;
    for (int k = 1; k < DEPTH; k++) begin
      write_onehot[k] = reg_write && (write_r == ADDR_W'(k));
    end
  end

  assign write_commit = |write_onehot;

  // Next-state for the storage array; entry 0 stays at its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    for (int k = 1; k < DEPTH; k++) begin
      if (write_onehot[k]) begin
        regs_d[k] = write_data;
      end
    end
  end

  // Debug state only moves on a committed (non-zero register) write.
  always_comb begin
    last_write_d  = last_write_q;
    write_count_d = write_count_q;
    if (write_commit) begin
      last_write_d = write_onehot;
      if (write_count_q != {CNT_W{1'b1}}) begin
        write_count_d = write_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      last_write_q  <= '0;
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      last_write_q  <= last_write_d;
      write_count_q <= write_count_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward in-flight write data. Gated by rst_n so reads stay zero during reset,
  // and by write_r != 0 so register 0 always reads zero.
  logic fwd1, fwd2;
  assign fwd1 = rst_n && reg_write && (write_r != '0) && (read_r1 == write_r);
  assign fwd2 = rst_n && reg_write && (write_r != '0) && (read_r2 == write_r);

  always_comb begin
    read_data1 = fwd1 ? write_data : regs_q[read_r1];
    read_data2 = fwd2 ? write_data : regs_q[read_r2];
  end
`else
  always_comb begin
    read_data1 = regs_q[read_r1];
    read_data2 = regs_q[read_r2];
  end
`endif

  assign last_write  = last_write_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_reg_file_onehot.sv
module tb_reg_file_onehot;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_r;
  logic [31:0] write_data;
  logic [4:0]  read_r1;
  logic [4:0]  read_r2;

  logic [31:0] rd1, rd2, onehot, last_w;
  logic [15:0] cnt;
  logic [31:0] rd1_s, rd2_s, onehot_s, last_w_s;
  logic [3:0]  cnt_s;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected values, pushed when stimulus is applied.
  logic [63:0] sb [$];

  // Bench-side reference model.
  logic [31:0] m_regs [32];
  logic [31:0] m_last;
  int          m_cnt;
  int          m_cnt4;

  reg_file_onehot #(.WIDTH(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write    (reg_write),
    .write_r      (write_r),
    .write_data   (write_data),
    .read_r1      (read_r1),
    .read_r2      (read_r2),
    .read_data1   (rd1),
    .read_data2   (rd2),
    .write_onehot (onehot),
    .last_write   (last_w),
    .write_count  (cnt)
  );

  // Narrow-counter instance for saturation checks; shares all inputs.
  reg_file_onehot #(.WIDTH(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write    (reg_write),
    .write_r      (write_r),
    .write_data   (write_data),
    .read_r1      (read_r1),
    .read_r2      (read_r2),
    .read_data1   (rd1_s),
    .read_data2   (rd2_s),
    .write_onehot (onehot_s),
    .last_write   (last_w_s),
    .write_count  (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sb_pop();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    m_last = '0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  // Applies one clock edge and updates the model with the write present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && reg_write && write_r != 0) begin
      m_regs[write_r] = write_data;
      m_last          = 32'h1 << write_r;
      if (m_cnt  < 65535) m_cnt++;
      if (m_cnt4 < 15)    m_cnt4++;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_r    = a;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b0; write_r = '0; write_data = '0;
    read_r1 = 5'd1; read_r2 = 5'd2;
    model_reset();

    // Reset state
    #2;
    sb.push_back(64'(0)); check("rst_rd1", 64'(rd1), sb_pop());
    sb.push_back(64'(0)); check("rst_rd2", 64'(rd2), sb_pop());
    sb.push_back(64'(0)); check("rst_last", 64'(last_w), sb_pop());
    sb.push_back(64'(0)); check("rst_cnt", 64'(cnt), sb_pop());
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Decode sweep with write-back
    for (int k = 0; k < 32; k++) begin
      reg_write = 1'b1; write_r = 5'(k); write_data = 32'hA5A5_0000 + 32'(k);
      #1;
      sb.push_back(64'((k == 0) ? 32'h0 : (32'h1 << k)));
      check($sformatf("onehot[%0d]", k), 64'(onehot), sb_pop());
      tick();
    end
    reg_write = 1'b0;
    for (int k = 0; k < 32; k++) begin
      read_r1 = 5'(k); read_r2 = 5'(31 - k);
      #1;
      sb.push_back(64'((k == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(k)));
      sb.push_back(64'(m_regs[31 - k]));
      check($sformatf("rd1[%0d]", k), 64'(rd1), sb_pop());
      check($sformatf("rd2[%0d]", 31 - k), 64'(rd2), sb_pop());
    end
    sb.push_back(64'(31)); check("sweep_cnt", 64'(cnt), sb_pop());
    sb.push_back(64'(32'h8000_0000)); check("sweep_last", 64'(last_w), sb_pop());

    // Register 0 protection
    read_r1 = 5'd0;
    write_reg(5'd0, 32'hFFFF_FFFF);
    #1;
    sb.push_back(64'(0)); check("r0_rd", 64'(rd1), sb_pop());
    sb.push_back(64'(m_cnt)); check("r0_cnt", 64'(cnt), sb_pop());
    sb.push_back(64'(m_last)); check("r0_last", 64'(last_w), sb_pop());

    // Same-cycle read/write
    write_reg(5'd7, 32'h1111_1111);
    read_r1 = 5'd7; reg_write = 1'b1; write_r = 5'd7; write_data = 32'h2222_2222;
    #1;
`ifdef REG_FILE_BYPASS_EN
    sb.push_back(64'(32'h2222_2222));
`else
    sb.push_back(64'(32'h1111_1111));
`endif
    check("rw_same", 64'(rd1), sb_pop());
    tick();
    reg_write = 1'b0;
    #1;
    sb.push_back(64'(32'h2222_2222)); check("rw_next", 64'(rd1), sb_pop());

    // Idle hold with write_r toggling
    read_r1 = 5'd5; read_r2 = 5'd7;
    for (int i = 0; i < 10; i++) begin
      write_r = 5'(i * 3 + 1); write_data = 32'hDEAD_0000 + 32'(i);
      tick();
      sb.push_back(64'(0)); check("idle_onehot", 64'(onehot), sb_pop());
    end
    sb.push_back(64'(m_regs[5])); check("idle_r5", 64'(rd1), sb_pop());
    sb.push_back(64'(32'h2222_2222)); check("idle_r7", 64'(rd2), sb_pop());
    sb.push_back(64'(m_cnt)); check("idle_cnt", 64'(cnt), sb_pop());
    sb.push_back(64'(32'h0000_0080)); check("idle_last", 64'(last_w), sb_pop());
    sb.push_back(64'(4'hF)); check("idle_cnt4", 64'(cnt_s), sb_pop());

    // Asynchronous mid-cycle reset, with a write held across the reset edge
    @(posedge clk); #3;
    reg_write = 1'b1; write_r = 5'd4; write_data = 32'h5555_AAAA;
    read_r1 = 5'd4; read_r2 = 5'd31;
    rst_n = 1'b0; model_reset();
    #1;
    sb.push_back(64'(0)); check("arst_rd1", 64'(rd1), sb_pop());
    sb.push_back(64'(0)); check("arst_rd2", 64'(rd2), sb_pop());
    sb.push_back(64'(0)); check("arst_last", 64'(last_w), sb_pop());
    sb.push_back(64'(0)); check("arst_cnt", 64'(cnt), sb_pop());
    tick();
    reg_write = 1'b0;
    sb.push_back(64'(0)); check("arst_wr_rd1", 64'(rd1), sb_pop());
    sb.push_back(64'(0)); check("arst_wr_cnt", 64'(cnt), sb_pop());
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) write_reg(5'd9, 32'h0900_0000 + 32'(i));
    read_r1 = 5'd9;
    #1;
    sb.push_back(64'(m_cnt4)); check("sat_cnt4", 64'(cnt_s), sb_pop());
    sb.push_back(64'(4'hF)); check("sat_cnt4_max", 64'(cnt_s), sb_pop());
    sb.push_back(64'(32'h0000_0200)); check("sat_last4", 64'(last_w_s), sb_pop());
    sb.push_back(64'(20)); check("sat_cnt16", 64'(cnt), sb_pop());
    sb.push_back(64'(32'h0900_0013)); check("sat_r9", 64'(rd1), sb_pop());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
